chunked_addsub: RTL and testbench

- Parametrised, multi-cycle two's-complement add/subtract unit for the MIPS ALU datapath.
- Generalises the fixed 32-bit operand-inverting XOR stage:
  - the inversion is folded in;
  - carry-in is driven from the sub control;
  - width is parametrised;
  - operands are processed CHUNK bits per cycle, so wide datapaths meet timing.
- Start/ready/done handshake to the ALU control FSM.
- Flag outputs (carry, signed overflow, zero) for branch and exception logic.

---
 rtl/alu_pkg.sv | 13 +
 rtl/cond_invert.sv | 12 +
 rtl/chunked_addsub.sv | 157 +++++++++++++++
 tb/tb_chunked_addsub.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control FSM states and add/sub op encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/cond_invert.sv
// Width-generic conditional inverter: out = in when inv=0, ~in when inv=1.
module cond_invert #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             inv,
    output logic [WIDTH-1:0] out
);

    assign out = in ^ {WIDTH{inv}};

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle two's-complement add/subtract, CHUNK bits per cycle, LSB chunk first.
//
// state | meaning
// IDLE  | ready=1, waiting for start; outputs hold the last completed result
// RUN   | one chunk of a + b_eff + carry per cycle
// DONE  | one-cycle done pulse, result and flags valid
module chunked_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_addsub: CHUNK must be >= 1 and divide WIDTH");
    end

    alu_state_e        state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    logic [WIDTH-1:0]  b_eff;
    logic [CHUNK:0]    chunk_sum;
    logic [WIDTH-1:0]  sum_full;
    int                chunk_lo;
    logic              last_chunk;

    cond_invert #(.WIDTH(WIDTH)) u_inv (
        .in  (b),
        .inv (sub),
        .out (b_eff)
    );

    always_comb begin
        chunk_lo   = int'(idx_q) * CHUNK;
        chunk_sum  = {1'b0, a_q[chunk_lo +: CHUNK]} + {1'b0, b_q[chunk_lo +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};
        sum_full   = sum_q;
        sum_full[chunk_lo +: CHUNK] = chunk_sum[CHUNK-1:0];
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        done_d      = done_q;
        ready_d     = ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = (sub == ALU_SUB);
                    idx_d   = '0;
                    ready_d = 1'b0;
                end
            end
            RUN: begin
                sum_d   = sum_full;
                carry_d = chunk_sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (last_chunk) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    result_d    = sum_full;
                    carry_out_d = chunk_sum[CHUNK];
                    // b_q already holds the inverted operand, so one rule covers add and sub
                    overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1])
                                && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d      = (sum_full == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Scoreboard bench for chunked_addsub: CHUNK=8 instance plus a degenerate CHUNK=32 instance.
module tb_chunked_addsub;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic        sub;
    logic [31:0] a, b;

    logic        ready0, done0, cout0, ovf0, zero0;
    logic [31:0] result0;
    logic        ready1, done1, cout1, ovf1, zero1;
    logic [31:0] result1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_r0 = '0;
    logic [31:0] last_r1 = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub), .a(a), .b(b),
        .ready(ready0), .done(done0), .result(result0),
        .carry_out(cout0), .overflow(ovf0), .zero(zero0)
    );

    chunked_addsub #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b),
        .ready(ready1), .done(done1), .result(result1),
        .carry_out(cout1), .overflow(ovf1), .zero(zero1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic ss);
        exp_t        e;
        logic [32:0] t;
        if (ss) t = {1'b0, aa} + {1'b0, ~bb} + 33'd1;
        else    t = {1'b0, aa} + {1'b0, bb};
        e.r = t[31:0];
        e.c = t[32];
        e.v = ss ? ((aa[31] != bb[31]) && (t[31] != aa[31]))
                 : ((aa[31] == bb[31]) && (t[31] != aa[31]));
        e.z = (t[31:0] == 32'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (q0.size() == 0) chk("spurious_done0", 1'b1, 1'b0);
            else begin
                exp_t e;
                e = q0.pop_front();
                chk("result0", result0, e.r);
                chk("carry0", cout0, e.c);
                chk("ovf0", ovf0, e.v);
                chk("zero0", zero0, e.z);
                last_r0 = e.r;
            end
        end
        if (rst_n && done1) begin
            if (q1.size() == 0) chk("spurious_done1", 1'b1, 1'b0);
            else begin
                exp_t e;
                e = q1.pop_front();
                chk("result1", result1, e.r);
                chk("carry1", cout1, e.c);
                chk("ovf1", ovf1, e.v);
                chk("zero1", zero1, e.z);
                last_r1 = e.r;
            end
        end
    end

    // Counts edges from E0 until done; checks latency, busy ready, pulse width and hold.
    task automatic wait_done(input int sel, input int elapsed, input int lat);
        int  cnt;
        bit  seen;
        cnt  = elapsed;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            cnt++;
            if ((sel == 0) ? done0 : done1) seen = 1;
            else chk("ready_busy", (sel == 0) ? ready0 : ready1, 1'b0);
        end
        if (!seen) begin
            chk("done_timeout", 1'b0, 1'b1);
        end else begin
            chk("latency", cnt, lat);
            chk("ready_in_done", (sel == 0) ? ready0 : ready1, 1'b0);
            @(posedge clk); #1;
            chk("done_pulse", (sel == 0) ? done0 : done1, 1'b0);
            chk("ready_idle", (sel == 0) ? ready0 : ready1, 1'b1);
            chk("hold", (sel == 0) ? result0 : result1, (sel == 0) ? last_r0 : last_r1);
        end
    endtask

    task automatic run_op(input int sel, input logic [31:0] aa, input logic [31:0] bb, input logic ss);
        @(negedge clk);
        a   = aa;
        b   = bb;
        sub = ss;
        if (sel == 0) begin start0 = 1'b1; q0.push_back(model(aa, bb, ss)); end
        else          begin start1 = 1'b1; q1.push_back(model(aa, bb, ss)); end
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        a   = $urandom;
        b   = $urandom;
        sub = 1'($urandom_range(0, 1));
        wait_done(sel, 0, (sel == 0) ? 4 : 1);
    endtask

    initial begin
        int seen_done;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        sub    = 1'b0;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready0, 1'b1);
        chk("rst_done", done0, 1'b0);
        chk("rst_result", result0, 32'd0);
        chk("rst_flags", {cout0, ovf0, zero0}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 32'd5, 32'd3, 1'b0);
        run_op(0, 32'h12345678, 32'h12345678, 1'b1);
        run_op(0, 32'h7FFFFFFF, 32'd1, 1'b0);
        run_op(0, 32'h80000000, 32'd1, 1'b1);
        run_op(0, 32'd0, 32'd1, 1'b1);
        run_op(0, 32'h000000FF, 32'd1, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(0, $urandom, $urandom, 1'($urandom_range(0, 1)));

        // start re-pulsed while busy must be ignored
        @(negedge clk);
        a = 32'd1; b = 32'd1; sub = 1'b0; start0 = 1'b1;
        q0.push_back(model(32'd1, 32'd1, 1'b0));
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        a = 32'd9; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done(0, 2, 4);
        chk("ignored_start_result", result0, 32'd2);

        // reset mid-operation aborts with no done pulse
        @(negedge clk);
        a = 32'd7; b = 32'd8; sub = 1'b0; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", ready0, 1'b1);
        chk("abort_result", result0, 32'd0);
        chk("abort_flags", {done0, cout0, ovf0, zero0}, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_r0 = '0;
        last_r1 = '0;
        seen_done = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done0) seen_done++;
        end
        chk("no_done_after_abort", seen_done, 0);
        chk("abort_hold_result", result0, 32'd0);

        run_op(1, 32'hFFFFFFFF, 32'd1, 1'b0);
        run_op(1, 32'h80000000, 32'd1, 1'b1);
        run_op(1, 32'd0, 32'd1, 1'b1);
        run_op(0, 32'h00FF00FF, 32'h00010001, 1'b0);

        repeat (3) @(posedge clk);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
